fetch_queue: RTL and testbench

- Small instruction queue between the instruction-memory response path and the decode stage.
- Buffers up to DEPTH fetched {pc, instruction} pairs with valid/ready handshakes on both sides.
- Presents the head entry's opcode field directly to the decode control logic.
- Supports pipeline flush on redirect; an epoch bit discards stale in-flight fetch responses.

---
 rtl/core_pkg.sv | 32 +++
 rtl/fq_storage.sv | 37 +++
 rtl/fetch_queue.sv | 152 +++++++++++++++
 tb/tb_fetch_queue.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the front end of the core: the canonical NOP
// encoding, the opcode field width and the base opcode encodings that the
// decode control logic switches on.
// No ports (package).
// ---------------------------------------------------------------------------
package core_pkg;

    localparam int          OPCODE_W = 7;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;   // addi x0, x0, 0

    // Base opcode encodings seen by decode control.
    typedef enum logic [OPCODE_W-1:0] {
        OP_LOAD   = 7'b000_0011,
        OP_IMM    = 7'b001_0011,
        OP_AUIPC  = 7'b001_0111,
        OP_STORE  = 7'b010_0011,
        OP_REG    = 7'b011_0011,
        OP_LUI    = 7'b011_0111,
        OP_BRANCH = 7'b110_0011,
        OP_JALR   = 7'b110_0111,
        OP_JAL    = 7'b110_1111,
        OP_SYSTEM = 7'b111_0011
    } opcode_e;

    // Extracts the opcode field from a 32-bit instruction word.
    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [31:0] inst);
        return inst[OPCODE_W-1:0];
    endfunction

endpackage

// File: rtl/fq_storage.sv
// ---------------------------------------------------------------------------
// fq_storage
// DEPTH x WIDTH register array for the fetch queue. One synchronous write
// port and one combinational read port. The array is deliberately not reset:
// validity is tracked entirely by the queue pointers and count.
// Ports:
//   clk      in   core clock
//   wr_en    in   write strobe
//   wr_addr  in   write index
//   wr_data  in   write data
//   rd_addr  in   read index
//   rd_data  out  read data (combinational)
// ---------------------------------------------------------------------------
module fq_storage #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port: store one entry on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Instruction queue between the I-memory response path and decode. Holds up
// to DEPTH {pc, inst} pairs, drops responses tagged with a stale epoch, and
// clears itself (toggling the epoch) on a redirect flush. The head entry is
// held in output registers that load NOP/0 whenever the queue will be empty,
// so decode never sees a garbage opcode.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   flush                  redirect: empty the queue, toggle epoch
//   if_valid/if_ready      fetch response handshake
//   if_inst, if_pc         fetch response payload
//   if_epoch               epoch tag of the response
//   cur_epoch              current epoch for tagging new requests
//   id_valid/id_ready      decode handshake
//   id_inst, id_pc         head entry
//   id_opcode              head opcode field
//   count, full, empty     occupancy status
// ---------------------------------------------------------------------------
module fetch_queue
    import core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       if_valid,
    input  logic [XLEN-1:0]            if_inst,
    input  logic [XLEN-1:0]            if_pc,
    input  logic                       if_epoch,
    output logic                       if_ready,
    output logic                       cur_epoch,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [XLEN-1:0]            id_inst,
    output logic [XLEN-1:0]            id_pc,
    output logic [OPCODE_W-1:0]        id_opcode,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [CNT_W-1:0]  count_r, count_nxt_s;
    logic              epoch_r;
    logic [XLEN-1:0]   id_inst_r, id_pc_r;
    logic [XLEN-1:0]   head_inst_nxt_s, head_pc_nxt_s;
    logic [2*XLEN-1:0] rd_data_s;
    logic              full_s, empty_s;
    logic              push_s, pop_s;

    // Status is decoded from the registered count, not held in separate flops.
    assign full_s  = (count_r == CNT_W'(DEPTH));
    assign empty_s = (count_r == {CNT_W{1'b0}});

    assign push_s = if_valid & ~full_s & (if_epoch == epoch_r) & ~flush;
    assign pop_s  = ~empty_s & id_ready & ~flush;

    fq_storage #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_storage (
        .clk     (clk),
        .wr_en   (push_s),
        .wr_addr (wr_ptr_r),
        .wr_data ({if_pc, if_inst}),
        .rd_addr (rd_ptr_nxt_s),
        .rd_data (rd_data_s)
    );

    // Next-state for pointers, count and the head register contents.
    always_comb begin
        wr_ptr_nxt_s    = wr_ptr_r;
        rd_ptr_nxt_s    = rd_ptr_r;
        count_nxt_s     = count_r;
        head_inst_nxt_s = XLEN'(NOP_INST);
        head_pc_nxt_s   = {XLEN{1'b0}};

        if (flush) begin
            wr_ptr_nxt_s = {PTR_W{1'b0}};
            rd_ptr_nxt_s = {PTR_W{1'b0}};
            count_nxt_s  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_W'(1);
                2'b01:   count_nxt_s = count_r - CNT_W'(1);
                default: count_nxt_s = count_r;
            endcase
        end

        // The next head is the entry at the next read pointer. When that slot
        // is the one being written this cycle (queue empty, or one entry that
        // is popped while pushing), the array still holds old data, so take
        // the incoming payload instead.
        if (count_nxt_s == {CNT_W{1'b0}}) begin
            head_inst_nxt_s = XLEN'(NOP_INST);
            head_pc_nxt_s   = {XLEN{1'b0}};
        end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_inst_nxt_s = if_inst;
            head_pc_nxt_s   = if_pc;
        end else begin
            head_inst_nxt_s = rd_data_s[XLEN-1:0];
            head_pc_nxt_s   = rd_data_s[2*XLEN-1:XLEN];
        end
    end

    // Queue state, epoch and registered head outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            epoch_r   <= 1'b0;
            id_inst_r <= XLEN'(NOP_INST);
            id_pc_r   <= {XLEN{1'b0}};
        end else begin
            wr_ptr_r  <= wr_ptr_nxt_s;
            rd_ptr_r  <= rd_ptr_nxt_s;
            count_r   <= count_nxt_s;
            epoch_r   <= flush ? ~epoch_r : epoch_r;
            id_inst_r <= head_inst_nxt_s;
            id_pc_r   <= head_pc_nxt_s;
        end
    end

    assign if_ready  = ~full_s;
    assign cur_epoch = epoch_r;
    assign id_valid  = ~empty_s;
    assign id_inst   = id_inst_r;
    assign id_pc     = id_pc_r;
    assign id_opcode = id_inst_r[OPCODE_W-1:0];
    assign count     = count_r;
    assign full      = full_s;
    assign empty     = empty_s;

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
// Directed, table-driven bench for fetch_queue (DEPTH=4, XLEN=32), plus
// hand-written sequences for back-to-back push/pop wrap and async reset.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0  = 32'h0050_0093;   // addi, opcode 0x13
    localparam logic [31:0] IA  = 32'h0000_0537;   // lui,  opcode 0x37
    localparam logic [31:0] IB  = 32'h0040_006F;   // jal,  opcode 0x6F
    localparam logic [31:0] IC  = 32'h0005_2503;   // lw,   opcode 0x03
    localparam logic [31:0] ID  = 32'h00A5_0533;   // add,  opcode 0x33

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_inst = 32'h0;
    logic [31:0] if_pc = 32'h0;
    logic        if_epoch = 1'b0;
    logic        if_ready;
    logic        cur_epoch;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int total = 0;
    int bad   = 0;

    fetch_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .if_valid  (if_valid),
        .if_inst   (if_inst),
        .if_pc     (if_pc),
        .if_epoch  (if_epoch),
        .if_ready  (if_ready),
        .cur_epoch (cur_epoch),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_inst   (id_inst),
        .id_pc     (id_pc),
        .id_opcode (id_opcode),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        v;
        logic        ep;
        logic        rdy;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] epc;     // expected id_pc after the edge
        logic [31:0] einst;   // expected id_inst after the edge
        logic [2:0]  ecnt;    // expected count after the edge
        logic        eep;     // expected cur_epoch after the edge
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic fl, input logic v, input logic ep, input logic rdy,
                       input logic [31:0] pc, input logic [31:0] inst,
                       input logic [31:0] epc, input logic [31:0] einst,
                       input logic [2:0] ecnt, input logic eep);
        vec_t t;
        t.fl = fl; t.v = v; t.ep = ep; t.rdy = rdy; t.pc = pc; t.inst = inst;
        t.epc = epc; t.einst = einst; t.ecnt = ecnt; t.eep = eep;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare every observable output against a full expected state.
    task automatic chk_state(input string tag, input logic [31:0] epc, input logic [31:0] einst,
                             input logic [2:0] ecnt, input logic eep);
        logic [31:0] ecnt32;
        logic [31:0] eop;
        ecnt32 = {29'd0, ecnt};
        eop    = {25'd0, einst[6:0]};
        chk({tag, ".count"},     {29'd0, count},      ecnt32);
        chk({tag, ".id_valid"},  {31'd0, id_valid},   {31'd0, (ecnt != 3'd0)});
        chk({tag, ".empty"},     {31'd0, empty},      {31'd0, (ecnt == 3'd0)});
        chk({tag, ".full"},      {31'd0, full},       {31'd0, (ecnt == 3'd4)});
        chk({tag, ".if_ready"},  {31'd0, if_ready},   {31'd0, (ecnt != 3'd4)});
        chk({tag, ".id_pc"},     id_pc,               epc);
        chk({tag, ".id_inst"},   id_inst,             einst);
        chk({tag, ".id_opcode"}, {25'd0, id_opcode},  eop);
        chk({tag, ".cur_epoch"}, {31'd0, cur_epoch},  {31'd0, eep});
    endtask

    task automatic drive(input logic fl, input logic v, input logic ep, input logic rdy,
                         input logic [31:0] pc, input logic [31:0] inst);
        flush = fl; if_valid = v; if_epoch = ep; id_ready = rdy; if_pc = pc; if_inst = inst;
    endtask

    initial begin
        //  fl    v     ep    rdy   pc          inst   | epc        einst ecnt  eep
        // single push, visible the cycle after; then pop it
        add(1'b0, 1'b1, 1'b0, 1'b0, 32'h100,    I0,     32'h100,    I0,   3'd1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,      32'h0,  32'h0,      NOP,  3'd0, 1'b0);
        // fill to full, fifth response ignored, drain in order
        add(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,      IA,     32'h0,      IA,   3'd1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 32'h4,      IB,     32'h0,      IA,   3'd2, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 32'h8,      IC,     32'h0,      IA,   3'd3, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 32'hC,      ID,     32'h0,      IA,   3'd4, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 32'h10,     I0,     32'h0,      IA,   3'd4, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,      32'h0,  32'h4,      IB,   3'd3, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,      32'h0,  32'h8,      IC,   3'd2, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,      32'h0,  32'hC,      ID,   3'd1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,      32'h0,  32'h0,      NOP,  3'd0, 1'b0);
        // count=3 then flush with a same-cycle response
        add(1'b0, 1'b1, 1'b0, 1'b0, 32'h20,     IA,     32'h20,     IA,   3'd1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 32'h24,     IB,     32'h20,     IA,   3'd2, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 32'h28,     IC,     32'h20,     IA,   3'd3, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h2C,     ID,     32'h0,      NOP,  3'd0, 1'b1);
        // stale epoch dropped, current epoch accepted
        add(1'b0, 1'b1, 1'b0, 1'b0, 32'h30,     IA,     32'h0,      NOP,  3'd0, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b0, 32'h34,     IB,     32'h34,     IB,   3'd1, 1'b1);
        // pop it, then five cycles of ready on an empty queue
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,      32'h0,  32'h0,      NOP,  3'd0, 1'b1);
        for (int i = 0; i < 5; i++)
            add(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  32'h0,  32'h0,      NOP,  3'd0, 1'b1);
        // back-to-back flushes toggle epoch twice, then refill to two
        add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,      32'h0,  32'h0,      NOP,  3'd0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,      32'h0,  32'h0,      NOP,  3'd0, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b0, 32'h40,     IA,     32'h40,     IA,   3'd1, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b0, 32'h44,     IB,     32'h40,     IA,   3'd2, 1'b1);

        // Reset state
        reset_n = 1'b0;
        #12;
        reset_n = 1'b1;
        #1;
        chk_state("reset", 32'h0, NOP, 3'd0, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].fl, vecs[i].v, vecs[i].ep, vecs[i].rdy, vecs[i].pc, vecs[i].inst);
            @(posedge clk);
            #1;
            chk_state($sformatf("vec%0d", i), vecs[i].epc, vecs[i].einst, vecs[i].ecnt, vecs[i].eep);
        end

        // Simultaneous push and pop at count=2 over 10 cycles (pointers wrap).
        for (int k = 0; k < 10; k++) begin
            logic [31:0] pc_k;
            pc_k = 32'h48 + 32'(4 * k);
            drive(1'b0, 1'b1, 1'b1, 1'b1, pc_k, {pc_k[24:0], 7'h33});
            @(posedge clk);
            #1;
            chk($sformatf("pp%0d.count", k), {29'd0, count}, 32'd2);
            chk($sformatf("pp%0d.id_pc", k), id_pc, 32'h44 + 32'(4 * k));
        end
        // Head after the loop was pushed with pc 0x68: inst = {0x68[24:0], 0x33}
        begin
            logic [31:0] exp_pc;
            exp_pc = 32'h68;
            chk("pp.id_inst", id_inst, {exp_pc[24:0], 7'h33});
        end

        // Asynchronous reset mid-cycle at count=2, epoch=1.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_state("async_rst", 32'h0, NOP, 3'd0, 1'b0);
        #10;
        reset_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
